// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared slot width, slot count and issuer state encoding
package parking_pkg;

  // Slot index width, shared with the parking controller
  localparam int SLOT_W        = 4;
  localparam int NUM_SLOTS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } issuer_state_t;

  // A slot index is usable only if it names an existing slot
  function automatic logic slot_valid(input logic [SLOT_W-1:0] slot, input int num_slots);
    return 32'(slot) < num_slots;
  endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// rtl/sensor_debouncer.sv - 2-flop synchroniser, debounce counter and rise pulse
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] count;

  // Synchronise, then accept a level change only after it has persisted;
  // rise fires on the same edge the debounced level goes 0->1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      count <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != level) begin
        if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          count <= '0;
          rise  <= sync2;
        end else begin
          count <= count + CW'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/parking_sensor_conditioner.sv
// rtl/parking_sensor_conditioner.sv - debounced, serialised entry/exit requests for the parking controller
module parking_sensor_conditioner
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int NUM_SLOTS       = NUM_SLOTS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entry_raw,
  input  logic              exit_raw,
  input  logic [SLOT_W-1:0] exit_slot_raw,
  output logic              entry_sensor,
  output logic              exit_sensor,
  output logic [SLOT_W-1:0] exit_slot,
  output logic              exit_slot_err,
  output logic              busy
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  logic              entry_rise;
  logic              exit_rise;
  logic [SLOT_W-1:0] slot_s1;
  logic [SLOT_W-1:0] slot_s2;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_pend;
  logic              entry_pend;
  logic              exit_pend;
  logic [HW-1:0]     hold_cnt;
  issuer_state_t     state;
  logic              can_launch;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
    .clk   (clk),
    .reset (reset),
    .raw   (entry_raw),
    .rise  (entry_rise)
  );

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
    .clk   (clk),
    .reset (reset),
    .raw   (exit_raw),
    .rise  (exit_rise)
  );

  // Slot bits are synchronised like the buttons; slot_q lags one stage so it
  // holds the value sampled on the edge where the exit level rose.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_s1 <= '0;
      slot_s2 <= '0;
      slot_q  <= '0;
    end else begin
      slot_s1 <= exit_slot_raw;
      slot_s2 <= slot_s1;
      slot_q  <= slot_s2;
    end
  end

  // The last hold-off cycle decides the next request directly, so back-to-back
  // requests are exactly HOLDOFF_CYCLES+1 cycles apart.
  assign can_launch = (state == IDLE) ||
                      ((state == HOLDOFF) && (hold_cnt == HW'(HOLDOFF_CYCLES - 1)));

  // Pending flags and issuer: single-depth capture, entry has fixed priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      entry_pend    <= 1'b0;
      exit_pend     <= 1'b0;
      slot_pend     <= '0;
      entry_sensor  <= 1'b0;
      exit_sensor   <= 1'b0;
      exit_slot     <= '0;
      exit_slot_err <= 1'b0;
    end else begin
      entry_sensor  <= 1'b0;
      exit_sensor   <= 1'b0;
      exit_slot_err <= 1'b0;

      if (entry_rise && !entry_pend) begin
        entry_pend <= 1'b1;
      end
      if (exit_rise) begin
        if (slot_valid(slot_q, NUM_SLOTS)) begin
          if (!exit_pend) begin
            exit_pend <= 1'b1;
            slot_pend <= slot_q;
          end
        end else begin
          exit_slot_err <= 1'b1;
        end
      end

      if (can_launch) begin
        if (entry_pend) begin
          state        <= ISSUE;
          entry_sensor <= 1'b1;
          entry_pend   <= 1'b0;
        end else if (exit_pend) begin
          state       <= ISSUE;
          exit_sensor <= 1'b1;
          exit_pend   <= 1'b0;
          exit_slot   <= slot_pend;
        end else begin
          state <= IDLE;
        end
      end else if (state == ISSUE) begin
        state    <= HOLDOFF;
        hold_cnt <= '0;
      end else if (state == HOLDOFF) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else begin
        state <= IDLE;
      end
    end
  end

  assign busy = (state != IDLE) | entry_pend | exit_pend;

endmodule

// File: doc/parking_sensor_conditioner.md
Name: parking_sensor_conditioner

Overview:
Input-conditioning stage that sits directly upstream of the parking controller FSM. It synchronises and debounces the raw entry and exit push-buttons or sensors, and converts each debounced press into a single-cycle request pulse. Requests are serialised with a hold-off window so the controller finishes one sequence before the next request arrives. It also captures and validates the exit slot number and holds it stable while the controller consumes it.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a level change (>=2)
HOLDOFF_CYCLES, 8, idle gap after each issued pulse; must be >=4 (controller sequence length)
NUM_SLOTS, 4, number of parking slots; exit slot values >= NUM_SLOTS are invalid

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
entry_raw  in  1  asynchronous, bouncy entry button/sensor
exit_raw  in  1  asynchronous, bouncy exit button/sensor
exit_slot_raw  in  4  asynchronous binary slot index from exit keypad/switches
entry_sensor  out  1  one-cycle entry request pulse to controller
exit_sensor  out  1  one-cycle exit request pulse to controller
exit_slot  out  4  validated slot index accompanying exit_sensor
exit_slot_err  out  1  one-cycle pulse: exit press with invalid slot (dropped)
busy  out  1  high while any request is pending, issuing or in hold-off

Behaviour:
- One clock; reset is synchronous and active-high, on clk/reset. Reset clears everything: all outputs 0, synchronisers 0, debounced levels 0, counters 0, pending flags 0, issuer in IDLE.
- Reset mid-operation discards any pending, issuing or hold-off activity. No pulse is emitted on the cycle reset is sampled.
- Synchronisation: 2-flop synchroniser on entry_raw, exit_raw and each exit_slot_raw bit.
- Debounce, per channel:
  - Counter increments while the synchronised level differs from the debounced level.
  - Counter clears on any match.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Edge detect: only a 0->1 debounced transition generates an event. 1->0 transitions are debounced but silent.
- An input held high through reset release produces one event after debounce.
- Exit event:
  - Slot is sampled from the synchronised exit_slot_raw on the same edge the debounced exit level rises.
  - If slot < NUM_SLOTS: set exit_pend and latch the slot into the pending register.
  - Otherwise: pulse exit_slot_err for 1 cycle; exit_pend is unchanged.
- Entry event: set entry_pend.
- Pending flags are single-depth. An event arriving while its flag is already set is dropped. A new exit event does not overwrite the latched slot.
- Issuer FSM, states IDLE, ISSUE, HOLDOFF:
  - IDLE: if entry_pend -> ISSUE(entry). Else if exit_pend -> ISSUE(exit). Entry has fixed priority.
  - ISSUE (1 cycle): the selected pulse output is high and the matching pend flag clears. For exit, exit_slot is driven from the latched slot.
  - HOLDOFF: counts HOLDOFF_CYCLES cycles, then -> IDLE. New events may set pend flags during HOLDOFF.
- entry_sensor and exit_sensor are registered, mutually exclusive, and never high on consecutive cycles.
- exit_slot is registered. It updates only on exit ISSUE and holds its value through HOLDOFF and beyond, so it is stable on the cycle after exit_sensor. Reset value is 0.
- Latency: with the issuer idle and no pending flag, the pulse output is high on the edge DEBOUNCE_CYCLES+3 after the first edge that samples the raw input high.
  - Edges 0-1: synchroniser.
  - Edges 2..D+1: debounce count; level flips at D+1.
  - Edge D+2: pend set.
  - Edge D+3: pulse.
- Simultaneous entry and exit events on the same cycle: both pend flags set. Entry is issued first; exit is issued after HOLDOFF, so pulses are HOLDOFF_CYCLES+1 cycles apart.
- busy = (state != IDLE) | entry_pend | exit_pend.

Decomposition:
- Package parking_pkg holds:
  - NUM_SLOTS default and SLOT_W (4).
  - Issuer state encodings IDLE/ISSUE/HOLDOFF.
  - Shared with the controller's slot width.
- One natural sub-module: sensor_debouncer. It contains the synchroniser, counter, debounced level and rise pulse, parameterised by DEBOUNCE_CYCLES, and is instantiated twice.
- The slot synchroniser and issuer stay in the top level.

Test Plan:
All scenarios use bench parameters D=4, H=8, NUM_SLOTS=4.
1. Clean entry press: entry_raw 0->1, held 20 cycles -> entry_sensor high exactly 1 cycle, at edge 7. busy=1 until HOLDOFF ends. No further pulse on release.
2. Bounce: exit_raw toggles 1,0,1,1,0 on single cycles, then steady 1 with exit_slot_raw=2 -> exactly one exit_sensor pulse, 7 edges after the steady 1 is first sampled. exit_slot=2 is held on the pulse cycle and the following cycle.
3. Simultaneous: entry_raw and exit_raw (slot 3) rise on the same edge -> entry_sensor at edge 7, exit_sensor at edge 16 with exit_slot=3. They never overlap.
4. Invalid slot: exit press with exit_slot_raw=5 -> exit_slot_err 1-cycle pulse at edge 6, no exit_sensor, exit_slot keeps its prior value.
5. Press during hold-off: second entry press accepted while HOLDOFF is active -> second pulse exactly when HOLDOFF ends (9 cycles after the first pulse), not earlier.
6. Reset mid-operation: assert reset 1 cycle during HOLDOFF with exit_pend set -> all outputs 0 next cycle, no exit pulse ever issued. A still-held exit_raw re-debounces and pulses once.
